// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester, response and ALU-side signal bundle for alu_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int XLEN    = 64,
    parameter int ALUOP_W = 5
);
    logic               req0_valid;
    logic               req0_ready;
    logic [ALUOP_W-1:0] req0_op;
    logic [XLEN-1:0]    req0_a;
    logic [XLEN-1:0]    req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [ALUOP_W-1:0] req1_op;
    logic [XLEN-1:0]    req1_a;
    logic [XLEN-1:0]    req1_b;
    logic               resp0_valid;
    logic               resp0_ready;
    logic [XLEN-1:0]    resp0_data;
    logic               resp1_valid;
    logic               resp1_ready;
    logic [XLEN-1:0]    resp1_data;
    logic               alu_valid;
    logic [ALUOP_W-1:0] alu_op;
    logic [XLEN-1:0]    alu_a;
    logic [XLEN-1:0]    alu_b;
    logic [XLEN-1:0]    alu_data;
    logic               alu_data_ok;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready,
        input  alu_data, alu_data_ok,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_data, resp1_valid, resp1_data,
        output alu_valid, alu_op, alu_a, alu_b
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready,
        output alu_data, alu_data_ok,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_data, resp1_valid, resp1_data,
        input  alu_valid, alu_op, alu_a, alu_b
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-port arbiter sharing one execute-stage ALU; one op in flight.
//            Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int XLEN    = 64,
    parameter int ALUOP_W = 5
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       flush,
    alu_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_phase;
    logic               r_owner;
    logic [ALUOP_W-1:0] r_op;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_result;

    logic               w_rr_ptr;
    logic               w_grant1;
    logic               w_idle_ok;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_accept;
    logic               w_resp_hs;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_rr_ptr = 1'b0;
`else
    logic r_rr_ptr;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_ready1;
        end
    end
    assign w_rr_ptr = r_rr_ptr;
`endif

    // Port 1 wins only when it is alone or it holds the round-robin token.
    assign w_grant1  = bus.req1_valid && (!bus.req0_valid || w_rr_ptr);
    assign w_idle_ok = (r_state == S_IDLE) && !flush && !reset;
    assign w_ready0  = w_idle_ok && bus.req0_valid && !w_grant1;
    assign w_ready1  = w_idle_ok && w_grant1;
    assign w_accept  = w_ready0 || w_ready1;
    assign w_resp_hs = r_owner ? bus.resp1_ready : bus.resp0_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_phase && bus.alu_data_ok) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || w_resp_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_phase  <= 1'b0;
            r_owner  <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_ready1;
                r_phase <= 1'b0;
                r_op    <= w_ready1 ? bus.req1_op : bus.req0_op;
                r_a     <= w_ready1 ? bus.req1_a  : bus.req0_a;
                r_b     <= w_ready1 ? bus.req1_b  : bus.req0_b;
            end else if (r_state == S_EXEC) begin
                // First EXEC cycle masks a done pulse left over from an aborted op.
                r_phase <= 1'b1;
            end
            if ((r_state == S_EXEC) && !flush && r_phase && bus.alu_data_ok) begin
                r_result <= bus.alu_data;
            end
        end
    end

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.alu_valid   = (r_state == S_EXEC);
    assign bus.alu_op      = r_op;
    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;
    assign bus.resp0_valid = (r_state == S_RESP) && !r_owner;
    assign bus.resp1_valid = (r_state == S_RESP) &&  r_owner;
    assign bus.resp0_data  = r_result;
    assign bus.resp1_data  = r_result;

endmodule
`default_nettype wire
